// File: rtl/sync_updown_ctr_if.sv
// rtl/sync_updown_ctr_if.sv - control/data bundle for the modulo-N up/down counter
interface sync_updown_ctr_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  // The controlling side drives strobes and load data, and observes count and flags.
  modport master (
    output en,
    output up,
    output load,
    output d,
    input  q,
    input  tc,
    input  wrap
  );

  // The counter consumes strobes and load data, and produces count and flags.
  modport slave (
    input  en,
    input  up,
    input  load,
    input  d,
    output q,
    output tc,
    output wrap
  );
endinterface

// File: rtl/sync_updown_ctr.sv
// rtl/sync_updown_ctr.sv - synchronous modulo-N up/down counter with saturating load and terminal count
module sync_updown_ctr #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                clk,
  input  logic                clear,
  sync_updown_ctr_if.slave    bus
);

  // Largest legal count; all arithmetic stays within WIDTH bits, so a
  // full-range modulus wraps by plain binary overflow.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;

  logic [WIDTH-1:0] q_reg;
  logic             wrap_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;

  assign at_max  = (q_reg == MAX_Q);
  assign at_zero = (q_reg == ZERO_Q);

  // Load data above the modulus is clamped to the top count rather than wrapped.
  assign load_val = (bus.d > MAX_Q) ? MAX_Q : bus.d;

  // Next-state selection with priority load > count; clear is applied in the register.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (bus.load) begin
      q_next    = load_val;
      wrap_next = 1'b0;
    end else if (bus.en) begin
      if (bus.up) begin
        q_next    = at_max ? ZERO_Q : (q_reg + ONE_Q);
        wrap_next = at_max;
      end else begin
        q_next    = at_zero ? MAX_Q : (q_reg - ONE_Q);
        wrap_next = at_zero;
      end
    end
  end

  // Count and wrap registers; clear overrides any pending load or count.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_reg    <= ZERO_Q;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  // Terminal count is combinational so a following stage sees it in the
  // same cycle as the edge that will wrap this one.
  assign bus.tc   = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));
  assign bus.q    = q_reg;
  assign bus.wrap = wrap_reg;

endmodule
